// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray-code helpers and depth check shared by the CDC FIFO pointer blocks
package fifo_pkg;

   // Works for any width up to 32 as long as the unused upper bits are zero.
   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it, within w bits.
   function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
      logic [31:0] b;
      b = g;
      for (int i = w - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// fifo_wptr_full_if: write-side request/status bundle of the CDC FIFO
interface fifo_wptr_full_if #(
   parameter int AW = 2
) ();
   logic          wr_en;
   logic [AW:0]   rptr_gray_sync;
   logic          overflow_clr;
   logic [AW:0]   wptr_bin;
   logic [AW:0]   wptr_gray;
   logic [AW-1:0] wr_addr;
   logic          wr_ram_en;
   logic          full;
   logic          almost_full;
   logic [AW:0]   wr_level;
   logic          overflow;

   modport master (
      output wr_en, rptr_gray_sync, overflow_clr,
      input  wptr_bin, wptr_gray, wr_addr, wr_ram_en, full, almost_full, wr_level, overflow
   );

   modport slave (
      input  wr_en, rptr_gray_sync, overflow_clr,
      output wptr_bin, wptr_gray, wr_addr, wr_ram_en, full, almost_full, wr_level, overflow
   );
endinterface

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write pointer, full/almost-full, level and sticky overflow in the wr_clk domain
module fifo_wptr_full
   import fifo_pkg::*;
#(
   parameter int FIFO_DEPTH         = 4,
   parameter int ALMOST_FULL_THRESH = FIFO_DEPTH - 1
) (
   input logic            wr_clk,
   input logic            wr_rst_n,
   fifo_wptr_full_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   // Full when the write Gray pointer equals the read one with its top two bits flipped.
   localparam logic [AW:0] FULL_MASK = (AW + 1)'(3) << (AW - 1);
   localparam logic [AW:0] AF_TH     = (AW + 1)'(ALMOST_FULL_THRESH);

   if (!is_pow2(FIFO_DEPTH)) begin : g_depth_chk
      $fatal(1, "FIFO_DEPTH must be a power of two >= 2");
   end
   if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > FIFO_DEPTH) begin : g_thresh_chk
      $fatal(1, "ALMOST_FULL_THRESH must be within 1..FIFO_DEPTH");
   end

   logic [AW:0] wptr_bin_q, wptr_bin_d;
   logic [AW:0] wptr_gray_q, wptr_gray_d;
   logic [AW:0] wr_level_q, wr_level_d;
   logic [AW:0] rbin_sync;
   logic        full_q, full_d;
   logic        almost_full_q, almost_full_d;
   logic        overflow_q, overflow_d;
   logic        w_inc;

   // Next pointer, flags and level; the synchronized read pointer is decoded without a register.
   always_comb begin
      w_inc         = bus.wr_en & ~full_q;
      rbin_sync     = (AW + 1)'(gray2bin(32'(bus.rptr_gray_sync), AW + 1));
      wptr_bin_d    = wptr_bin_q + (AW + 1)'(w_inc);
      wptr_gray_d   = (AW + 1)'(bin2gray(32'(wptr_bin_d)));
      full_d        = wptr_gray_d == (bus.rptr_gray_sync ^ FULL_MASK);
      wr_level_d    = wptr_bin_d - rbin_sync;
      almost_full_d = wr_level_d >= AF_TH;
      overflow_d    = (bus.wr_en & full_q) | (overflow_q & ~bus.overflow_clr);
   end

   // State registers; reset asserts asynchronously.
   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         wptr_bin_q    <= '0;
         wptr_gray_q   <= '0;
         wr_level_q    <= '0;
         full_q        <= 1'b0;
         almost_full_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         wptr_bin_q    <= wptr_bin_d;
         wptr_gray_q   <= wptr_gray_d;
         wr_level_q    <= wr_level_d;
         full_q        <= full_d;
         almost_full_q <= almost_full_d;
         overflow_q    <= overflow_d;
      end
   end

   assign bus.wptr_bin    = wptr_bin_q;
   assign bus.wptr_gray   = wptr_gray_q;
   assign bus.wr_addr     = wptr_bin_q[AW-1:0];
   assign bus.wr_ram_en   = w_inc;
   assign bus.full        = full_q;
   assign bus.almost_full = almost_full_q;
   assign bus.wr_level    = wr_level_q;
   assign bus.overflow    = overflow_q;

endmodule
